// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath definitions: opcodes, fetch FSM states and the fetch buffer payload.
// Imported by the fetch stage, its buffer and the decode-side consumers.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    // ST_HALT is only reachable once a misaligned redirect has been seen
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FULL,
        ST_DRAIN,
        ST_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [6:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: imem req/ack read port, decode valid/ready port, redirect input, fault flag.
// master = fetch stage, slave = memory/decode/execute environment.
interface instr_fetch_if;
    import riscv_pkg::*;

    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [XLEN-1:0]    if_pc;
    logic               if_ready;

    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               fetch_fault;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output if_valid, if_instr, if_pc,
        input  if_ready,
        input  redirect_valid, redirect_pc,
        output fetch_fault
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  if_valid, if_instr, if_pc,
        output if_ready,
        output redirect_valid, redirect_pc,
        input  fetch_fault
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous {pc, instr} buffer with flush; push-to-head visible one cycle later.
// Push when full and pop when empty are ignored; flush wins over push/pop.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  fetch_entry_t           i_dat,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output fetch_entry_t           o_dat,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dat   = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Storage is cleared on reset so the head reads as zero out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_dat;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads imem over req/ack, buffers into fetch_fifo (ack to if_valid: 1 cycle).
// Stalls requests while the buffer is full; FETCH_MISALIGN_CHECK_EN enables the sticky misaligned-redirect fault.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_tgt;
    logic [XLEN-1:0] w_tgt_nxt;
    logic            r_fault;
    logic            w_fault_nxt;

    logic            w_done;
    logic            w_inflight;
    logic            w_xfer;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic            w_full;
    logic            w_empty;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_after;
    fetch_entry_t    w_push_dat;
    fetch_entry_t    w_head;
    logic            w_misalign;
    logic [XLEN-1:0] w_redir_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_misalign = |bus.redirect_pc[1:0];
    assign w_redir_pc = bus.redirect_pc;
    assign bus.fetch_fault = r_fault;
`else
    assign w_misalign = 1'b0;
    assign w_redir_pc = bus.redirect_pc & ~32'h3;
    assign bus.fetch_fault = 1'b0;
`endif

    // Request depends only on registered state, never on if_ready/redirect
    assign bus.imem_req  = ((r_state == ST_FETCH) && !w_full) || (r_state == ST_DRAIN);
    assign bus.imem_addr = r_pc;

    assign bus.if_valid = !w_empty;
    assign bus.if_instr = w_head.instr;
    assign bus.if_pc    = w_head.pc;

    assign w_done        = bus.imem_req && bus.imem_ack;
    assign w_inflight    = bus.imem_req && !bus.imem_ack;
    assign w_xfer        = bus.if_valid && bus.if_ready;
    assign w_pop         = w_xfer && !bus.redirect_valid;
    assign w_count_after = w_count + CNT_W'(1) - CNT_W'(w_xfer);
    assign w_push_dat    = '{pc: r_pc, instr: bus.imem_rdata};

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_tgt_nxt   = r_tgt;
        w_fault_nxt = r_fault;
        w_push      = 1'b0;
        w_flush     = 1'b0;

        case (r_state)
            ST_IDLE: w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (w_done) begin
                    w_push   = 1'b1;
                    w_pc_nxt = r_pc + PC_INC;
                    if (w_count_after == CNT_W'(FIFO_DEPTH)) begin
                        w_state_nxt = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (w_xfer) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (w_done) begin
                    w_pc_nxt    = r_tgt;
                    w_state_nxt = r_fault ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_IDLE;
        endcase

        // Redirect overrides everything above; an outstanding request keeps its address until acked
        if (bus.redirect_valid && (r_state != ST_HALT)) begin
            w_flush = 1'b1;
            w_push  = 1'b0;
            if (w_misalign) begin
                w_fault_nxt = 1'b1;
                w_pc_nxt    = r_pc;
                w_state_nxt = w_inflight ? ST_DRAIN : ST_HALT;
            end else if (w_inflight) begin
                w_pc_nxt    = r_pc;
                w_tgt_nxt   = w_redir_pc;
                w_state_nxt = ST_DRAIN;
            end else begin
                w_pc_nxt    = w_redir_pc;
                w_state_nxt = r_fault ? ST_HALT : ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_tgt   <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_tgt   <= w_tgt_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_dat   (w_push_dat),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected {pc, instr} stream queued by stimulus, checked by a monitor.
module tb_instr_fetch;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic ack_tie;
    logic ack_pulse;

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    fetch_entry_t exp_q[$];

    always #5 clk = ~clk;

    instr_fetch_if bus();

    instr_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0033;
        if (a == 32'h4) return 32'h0000_0003;
        return {a[24:0], 7'b0010011};
    endfunction

    assign bus.imem_ack   = ack_tie | ack_pulse;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_block(input logic [31:0] start);
        logic [31:0] a;
        exp_q.delete();
        a = start;
        for (int i = 0; i < 48; i++) begin
            exp_q.push_back('{pc: a, instr: mem_word(a)});
            a = a + 32'd4;
        end
    endtask

    // Scoreboard monitor
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (bus.imem_req && bus.imem_ack) done_cnt++;
                if (bus.if_valid && bus.if_ready && !bus.redirect_valid) begin
                    xfer_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: got pc=%h instr=%h, expected no transfer",
                                 bus.if_pc, bus.if_instr);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.if_pc !== e.pc || bus.if_instr !== e.instr) begin
                            errors++;
                            $display("FAIL sb_data: got pc=%h instr=%h, expected pc=%h instr=%h",
                                     bus.if_pc, bus.if_instr, e.pc, e.instr);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int d0;
        bit found;

        rst_n              = 1'b0;
        ack_tie            = 1'b1;
        ack_pulse          = 1'b0;
        bus.if_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (3) step();

        @(negedge clk);
        check32("rst_req",   32'(bus.imem_req), 32'h0);
        check32("rst_addr",  bus.imem_addr, 32'h0);
        check32("rst_valid", 32'(bus.if_valid), 32'h0);
        check32("rst_instr", bus.if_instr, 32'h0);
        check32("rst_pc",    bus.if_pc, 32'h0);
        check32("rst_fault", 32'(bus.fetch_fault), 32'h0);

        // Streaming from reset, zero-wait memory
        step();
        load_block(32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check32("c1_req", 32'(bus.imem_req), 32'h0);
        @(negedge clk);
        check32("c2_req",  32'(bus.imem_req), 32'h1);
        check32("c2_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        check32("c3_valid",  32'(bus.if_valid), 32'h1);
        check32("c3_instr",  bus.if_instr, 32'h33);
        check32("c3_opcode", 32'(opcode_of(bus.if_instr)), 32'(OP_R_TYPE));
        check32("c3_pc",     bus.if_pc, 32'h0);
        @(negedge clk);
        check32("c4_instr",  bus.if_instr, 32'h03);
        check32("c4_opcode", 32'(opcode_of(bus.if_instr)), 32'(OP_LOAD));
        check32("c4_pc",     bus.if_pc, 32'h4);
        step();
        n0 = xfer_cnt;
        repeat (6) step();
        check32("throughput", 32'(xfer_cnt - n0), 32'd6);

        // Decode stalled from reset: buffer fills after two completions
        rst_n        = 1'b0;
        bus.if_ready = 1'b0;
        repeat (2) step();
        load_block(32'h0);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (12) step();
        check32("stall_completions", 32'(done_cnt - d0), 32'd2);
        @(negedge clk);
        check32("full_req", 32'(bus.imem_req), 32'h0);
        step();
        bus.if_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.imem_req) begin
                found = 1'b1;
                break;
            end
        end
        check32("resume_req",  32'(found), 32'h1);
        check32("resume_addr", bus.imem_addr, 32'h8);

        // Redirect while a slow request is outstanding
        rst_n   = 1'b0;
        ack_tie = 1'b0;
        step();
        step();
        load_block(32'h0);
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check32("slow_req",  32'(bus.imem_req), 32'h1);
        check32("slow_addr", bus.imem_addr, 32'h0);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        load_block(32'h100);
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check32("drain_req",  32'(bus.imem_req), 32'h1);
        check32("drain_addr", bus.imem_addr, 32'h0);
        step();
        ack_pulse = 1'b1;
        step();
        ack_pulse = 1'b0;
        @(negedge clk);
        check32("drain_valid", 32'(bus.if_valid), 32'h0);
        check32("redir_addr",  bus.imem_addr, 32'h100);
        step();
        ack_tie = 1'b1;
        repeat (5) step();

        // Redirect coinciding with completion and a pop
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        load_block(32'h200);
        @(negedge clk);
        check32("coin_pre_valid", 32'(bus.if_valid), 32'h1);
        check32("coin_pre_req",   32'(bus.imem_req), 32'h1);
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check32("coin_valid", 32'(bus.if_valid), 32'h0);
        check32("coin_addr",  bus.imem_addr, 32'h200);
        repeat (4) step();

        // PC wrap at the top of the address space
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        load_block(32'hFFFF_FFFC);
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check32("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        @(negedge clk);
        check32("wrap_addr1", bus.imem_addr, 32'h0);
        repeat (4) step();

        // Misaligned redirect
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
`ifdef FETCH_MISALIGN_CHECK_EN
        exp_q.delete();
`else
        load_block(32'h100);
`endif
        step();
        bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        @(negedge clk);
        check32("mis_fault", 32'(bus.fetch_fault), 32'h1);
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.imem_req) found = 1'b1;
        end
        check32("mis_no_req", 32'(found), 32'h0);
`else
        @(negedge clk);
        check32("mis_addr",  bus.imem_addr, 32'h100);
        check32("mis_fault", 32'(bus.fetch_fault), 32'h0);
        repeat (4) step();
`endif
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
